// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Signed operations run on magnitudes and are sign-corrected in a final FIX cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] Operand_A,
  input  logic [DATA_WIDTH-1:0] Operand_B,
  input  logic                  Write_HI,
  input  logic                  Write_LO,
  input  logic [DATA_WIDTH-1:0] Move_Data,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Div_By_Zero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              op_q;
  logic                    sign_a_q;
  logic                    sign_b_q;
  logic [DATA_WIDTH-1:0]   opa_q;
  logic [DATA_WIDTH-1:0]   opb_q;
  logic [DATA_WIDTH:0]     acc_q;
  logic [DATA_WIDTH-1:0]   q_q;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic                    done_q;
  logic                    dbz_q;

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic                    op_signed;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   mag_a;
  logic [DATA_WIDTH-1:0]   mag_b;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_shift;
  logic [DATA_WIDTH+1:0]   div_trial;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   fix_hi;
  logic [DATA_WIDTH-1:0]   fix_lo;

  // Two's-complement negate when requested.
  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] x,
                                                   input logic neg);
    neg_if = neg ? (~x + DATA_WIDTH'(1)) : x;
  endfunction

  // Double-width negate for the full product.
  function automatic logic [2*DATA_WIDTH-1:0] neg_wide_if(input logic [2*DATA_WIDTH-1:0] x,
                                                          input logic neg);
    neg_wide_if = neg ? (~x + (2*DATA_WIDTH)'(1)) : x;
  endfunction

  // MULT (00) and DIV (10) are the signed ops; magnitude of -2^(W-1) stays 2^(W-1) unsigned.
  assign op_signed = ~Op[0];
  assign a_s       = Operand_A;
  assign b_s       = Operand_B;
  assign a_neg     = op_signed && (a_s < 0);
  assign b_neg     = op_signed && (b_s < 0);
  assign mag_a     = neg_if(Operand_A, a_neg);
  assign mag_b     = neg_if(Operand_B, b_neg);

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set.
  assign mul_sum   = {1'b0, acc_q[DATA_WIDTH-1:0]} + (q_q[0] ? {1'b0, opa_q} : '0);
  // Divide step: shift the next dividend bit into the remainder and trial-subtract.
  assign div_shift = {acc_q[DATA_WIDTH-1:0], q_q[DATA_WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opb_q};

  // Sign correction and divide-by-zero override for the FIX-cycle write.
  always_comb begin
    prod   = neg_wide_if({acc_q[DATA_WIDTH-1:0], q_q}, sign_a_q ^ sign_b_q);
    fix_hi = prod[2*DATA_WIDTH-1:DATA_WIDTH];
    fix_lo = prod[DATA_WIDTH-1:0];
    if (op_q[1]) begin
      if (opb_q == '0) begin
        fix_hi = neg_if(opa_q, sign_a_q);
        fix_lo = '1;
      end else begin
        fix_hi = neg_if(acc_q[DATA_WIDTH-1:0], sign_a_q);
        fix_lo = neg_if(q_q, sign_a_q ^ sign_b_q);
      end
    end
  end

  // Next-state logic: IDLE -> RUN (DATA_WIDTH steps) -> FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM register, step counter, latched op and operand signs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && Start) begin
        op_q     <= Op;
        sign_a_q <= a_neg;
        sign_b_q <= b_neg;
        cnt_q    <= CNT_W'(DATA_WIDTH - 1);
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Iteration datapath: operand magnitudes, accumulator/remainder and multiplier/quotient.
  always_ff @(posedge Clock) begin
    if (state_q == IDLE && Start) begin
      opa_q <= mag_a;
      opb_q <= mag_b;
      acc_q <= '0;
      q_q   <= Op[1] ? mag_a : mag_b;
    end else if (state_q == RUN) begin
      if (op_q[1]) begin
        if (!div_trial[DATA_WIDTH+1]) begin
          acc_q <= div_trial[DATA_WIDTH:0];
          q_q   <= {q_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          acc_q <= div_shift;
          q_q   <= {q_q[DATA_WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_q <= {1'b0, mul_sum[DATA_WIDTH:1]};
        q_q   <= {mul_sum[0], q_q[DATA_WIDTH-1:1]};
      end
    end
  end

  // Architectural HI/LO plus the Done / Div_By_Zero pulses; MTHI/MTLO only in IDLE without Start.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      dbz_q  <= (state_q == FIX) && op_q[1] && (opb_q == '0);
      if (state_q == FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (state_q == IDLE && !Start) begin
        if (Write_HI) hi_q <= Move_Data;
        if (Write_LO) lo_q <= Move_Data;
      end
    end
  end

  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign Div_By_Zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Operand_A;
  logic [31:0] Operand_B;
  logic        Write_HI;
  logic        Write_LO;
  logic [31:0] Move_Data;
  logic        Busy;
  logic        Done;
  logic        Div_By_Zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec = 0;
  int n_err = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Write_HI(Write_HI), .Write_LO(Write_LO), .Move_Data(Move_Data),
    .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero), .HI(HI), .LO(LO)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions of each op.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      p;
    logic [63:0] up;
    int          sa, sb;
    ez = 1'b0;
    eh = '0;
    el = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin
        p  = longint'(sa) * longint'(sb);
        up = p;
        eh = up[63:32];
        el = up[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eh = 32'd0; el = 32'h8000_0000;
        end else begin
          el = sa / sb;
          eh = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endtask

  // Launch one op; optionally inject Start + Write_HI at cycle inj while busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj);
    logic [31:0] eh, el, old_hi, old_lo;
    logic        ez;
    int          cyc, busy_cnt;
    logic        held;
    model(op, a, b, eh, el, ez);
    old_hi    = HI;
    old_lo    = LO;
    Op        = op;
    Operand_A = a;
    Operand_B = b;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
    Operand_A = $urandom;
    Operand_B = $urandom;
    Op        = 2'($urandom_range(0, 3));
    cyc       = 1;
    busy_cnt  = 0;
    held      = 1'b1;
    while (!Done && cyc < 100) begin
      if (Busy) busy_cnt++;
      if (HI !== old_hi || LO !== old_lo) held = 1'b0;
      if (cyc == inj) begin
        Start     = 1'b1;
        Write_HI  = 1'b1;
        Write_LO  = 1'b1;
        Move_Data = 32'h5A5A_5A5A;
      end else begin
        Start    = 1'b0;
        Write_HI = 1'b0;
        Write_LO = 1'b0;
      end
      tick();
      cyc++;
    end
    Start    = 1'b0;
    Write_HI = 1'b0;
    Write_LO = 1'b0;
    check("done_cycle", 64'(cyc), 64'd34);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("hilo_held", {63'd0, held}, 64'd1);
    check("busy_at_done", {63'd0, Busy}, 64'd0);
    check("hi", {32'd0, HI}, {32'd0, eh});
    check("lo", {32'd0, LO}, {32'd0, el});
    check("div_by_zero", {63'd0, Div_By_Zero}, {63'd0, ez});
  endtask

  initial begin
    logic [31:0] a, b, hi_keep, lo_keep;
    logic        saw_done;
    int          r;
    Reset     = 1'b1;
    Start     = 1'b0;
    Op        = 2'b00;
    Operand_A = '0;
    Operand_B = '0;
    Write_HI  = 1'b0;
    Write_LO  = 1'b0;
    Move_Data = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_dbz", {63'd0, Div_By_Zero}, 64'd0);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);

    // Directed cases, issued back to back (each Start lands in the previous Done cycle).
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b10, 32'h0000_1234, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);

    // Done is a single-cycle pulse.
    tick();
    check("done_pulse", {63'd0, Done}, 64'd0);
    check("dbz_pulse", {63'd0, Div_By_Zero}, 64'd0);

    // Start and Write_* during Busy are ignored and not queued.
    run_op(2'b00, 32'd12345, 32'hFFFF_FF00, 10);
    hi_keep = HI;
    lo_keep = LO;
    tick();
    tick();
    check("no_queue_busy", {63'd0, Busy}, 64'd0);
    check("no_queue_hi", {32'd0, HI}, {32'd0, hi_keep});
    check("no_queue_lo", {32'd0, LO}, {32'd0, lo_keep});

    // MTHI / MTLO, both together, and Start winning over Write_*.
    Write_HI = 1'b1; Move_Data = 32'h1111_2222;
    tick();
    Write_HI = 1'b0;
    check("mthi", {32'd0, HI}, 64'h1111_2222);
    check("mthi_lo_kept", {32'd0, LO}, {32'd0, lo_keep});
    Write_HI = 1'b1; Write_LO = 1'b1; Move_Data = 32'h3333_4444;
    tick();
    Write_HI = 1'b0; Write_LO = 1'b0;
    check("mt_both_hi", {32'd0, HI}, 64'h3333_4444);
    check("mt_both_lo", {32'd0, LO}, 64'h3333_4444);
    Start = 1'b1; Op = 2'b01; Operand_A = 32'd6; Operand_B = 32'd7;
    Write_HI = 1'b1; Write_LO = 1'b1; Move_Data = 32'hDEAD_0000;
    tick();
    Start = 1'b0; Write_HI = 1'b0; Write_LO = 1'b0;
    check("start_wins_busy", {63'd0, Busy}, 64'd1);
    check("start_wins_hi", {32'd0, HI}, 64'h3333_4444);
    r = 0;
    while (!Done && r < 100) begin
      tick();
      r++;
    end
    check("start_wins_res_hi", {32'd0, HI}, 64'd0);
    check("start_wins_res_lo", {32'd0, LO}, 64'd42);

    // Randomized ops with biased divisors.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case (r)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, 0);
    end

    // Reset mid-operation aborts with no partial result and no Done.
    run_op(2'b01, 32'd9, 32'd9, 0);
    Op = 2'b11; Operand_A = 32'hFFFF_0000; Operand_B = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_hi", {32'd0, HI}, 64'd0);
    check("abort_lo", {32'd0, LO}, 64'd0);
    check("abort_done", {63'd0, Done}, 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (Done || Busy) saw_done = 1'b1;
      tick();
    end
    check("abort_quiet", {63'd0, saw_done}, 64'd0);
    Write_LO = 1'b1; Move_Data = 32'h0000_ABCD;
    tick();
    Write_LO = 1'b0;
    check("mtlo_after_abort", {32'd0, LO}, 64'h0000_ABCD);
    check("hi_after_abort", {32'd0, HI}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
